unsigned_int_to_single: RTL and testbench



---
 rtl/unsigned_int_to_single.sv | 132 +++++++++++++
 tb/tb_unsigned_int_to_single.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_int_to_single.sv
// Multi-cycle 32-bit unsigned integer to IEEE-754 single converter, round to nearest even.
// Define UNSIGNED_INT_TO_SINGLE_FAST_NORM_EN for a single-cycle leading-zero normaliser.
module unsigned_int_to_single (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic        a_stb,
  output logic        a_ack,
  output logic [31:0] z,
  output logic        z_stb,
  input  logic        z_ack
);

  typedef enum logic [2:0] {
    GET_A, CONVERT, NORMALISE, ROUND, PACK, PUT_Z
  } state_t;

  state_t      state, state_next;
  logic [31:0] m, m_next;
  logic [5:0]  e, e_next;
  logic [31:0] z_next;
  logic        a_ack_next, z_stb_next;

  logic [24:0] m_inc;
  logic        round_up;
  logic [7:0]  exp_biased;

  assign m_inc      = {1'b0, m[31:8]} + 25'd1;
  assign round_up   = m[7] && ((|m[6:0]) || m[8]);
  assign exp_biased = {2'b00, e} + 8'd127;

`ifdef UNSIGNED_INT_TO_SINGLE_FAST_NORM_EN
  // Only reached with a nonzero operand, so some bit is always set.
  function automatic logic [4:0] count_lz(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

  logic [4:0] lz;
  assign lz = count_lz(m);
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    m_next     = m;
    e_next     = e;
    z_next     = z;
    case (state)
      GET_A: begin
        if (a_stb && a_ack) begin
          m_next     = a;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (m == 32'd0) begin
          z_next     = 32'h0000_0000;
          state_next = PUT_Z;
        end else begin
          e_next     = 6'd31;
          state_next = NORMALISE;
        end
      end
      NORMALISE: begin
`ifdef UNSIGNED_INT_TO_SINGLE_FAST_NORM_EN
        m_next     = m << lz;
        e_next     = 6'd31 - {1'b0, lz};
        state_next = ROUND;
`else
        if (!m[31]) begin
          m_next = m << 1;
          e_next = e - 6'd1;
        end else begin
          state_next = ROUND;
        end
`endif
      end
      ROUND: begin
        if (round_up) begin
          // All-ones mantissa overflows to the next power of two.
          if (m_inc[24]) begin
            m_next[31:8] = 24'h80_0000;
            e_next       = e + 6'd1;
          end else begin
            m_next[31:8] = m_inc[23:0];
          end
        end
        state_next = PACK;
      end
      PACK: begin
        z_next     = {1'b0, exp_biased, m[30:8]};
        state_next = PUT_Z;
      end
      PUT_Z: begin
        if (z_stb && z_ack) state_next = GET_A;
      end
      default: state_next = GET_A;
    endcase
  end

  // Handshake outputs are registered so they sit low through reset and
  // a_ack first rises on the edge after release.
  assign a_ack_next = (state_next == GET_A);
  assign z_stb_next = (state_next == PUT_Z);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GET_A;
      m     <= 32'd0;
      e     <= 6'd0;
      z     <= 32'd0;
      a_ack <= 1'b0;
      z_stb <= 1'b0;
    end else begin
      state <= state_next;
      m     <= m_next;
      e     <= e_next;
      z     <= z_next;
      a_ack <= a_ack_next;
      z_stb <= z_stb_next;
    end
  end

endmodule

// File: tb/tb_unsigned_int_to_single.sv
// Directed self-checking bench for unsigned_int_to_single; latency expectations follow
// UNSIGNED_INT_TO_SINGLE_FAST_NORM_EN when defined.
module tb_unsigned_int_to_single;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic        a_stb;
  logic        a_ack;
  logic [31:0] z;
  logic        z_stb;
  logic        z_ack;

  int checks   = 0;
  int failures = 0;

  unsigned_int_to_single dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .a_stb (a_stb),
    .a_ack (a_ack),
    .z     (z),
    .z_stb (z_stb),
    .z_ack (z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edges from the operand handshake until z_stb is seen high.
  function automatic int exp_lat(input logic [31:0] val, input int lz);
    if (val == 32'd0) return 1;
`ifdef UNSIGNED_INT_TO_SINGLE_FAST_NORM_EN
    return 4;
`else
    return 4 + lz;
`endif
  endfunction

  task automatic wait_a_ack();
    int k;
    k = 0;
    while (a_ack !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("a_ack_ready", {31'd0, a_ack}, 32'd1);
  endtask

  task automatic wait_z_stb(output int k);
    k = 0;
    while (k < 100) begin
      @(posedge clk); #1;
      k++;
      if (z_stb === 1'b1) break;
    end
  endtask

  // One full conversion with z_ack held high by the caller.
  task automatic do_conv(input string tag, input logic [31:0] val, input int lz,
                         input logic [31:0] exp_z);
    int k;
    wait_a_ack();
    @(negedge clk);
    a     = val;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    check({tag, "_ack_drop"}, {31'd0, a_ack}, 32'd0);
    wait_z_stb(k);
    check({tag, "_latency"}, 32'(k), 32'(exp_lat(val, lz)));
    check({tag, "_z"}, z, exp_z);
    @(posedge clk); #1;
    check({tag, "_stb_drop"}, {31'd0, z_stb}, 32'd0);
    check({tag, "_ack_back"}, {31'd0, a_ack}, 32'd1);
  endtask

  initial begin
    int k;
    logic [31:0] z_held;
    rst   = 1'b1;
    a     = 32'd0;
    a_stb = 1'b0;
    z_ack = 1'b1;

    // Reset values, held across an active edge.
    #12;
    check("rst_a_ack", {31'd0, a_ack}, 32'd0);
    check("rst_z_stb", {31'd0, z_stb}, 32'd0);
    check("rst_z", z, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_a_ack_low", {31'd0, a_ack}, 32'd0);
    @(posedge clk); #1;
    check("rel_a_ack_high", {31'd0, a_ack}, 32'd1);

    do_conv("zero",     32'h0000_0000, 0,  32'h0000_0000);
    do_conv("one",      32'h0000_0001, 31, 32'h3F80_0000);
    do_conv("allones",  32'hFFFF_FFFF, 0,  32'h4F80_0000);
    do_conv("tie_down", 32'h0100_0001, 7,  32'h4B80_0000);
    do_conv("tie_up",   32'h0100_0003, 7,  32'h4B80_0002);
    do_conv("above_up", 32'h0100_0007, 7,  32'h4B80_0004);
    do_conv("sticky",   32'h0200_0003, 6,  32'h4C00_0001);
    do_conv("below",    32'h0200_0001, 6,  32'h4C00_0000);
    do_conv("exact24",  32'h00FF_FFFF, 8,  32'h4B7F_FFFF);

    // Backpressure: a_stb stays high with changing data while the result is held.
    z_ack = 1'b0;
    wait_a_ack();
    @(negedge clk);
    a     = 32'h0100_0003;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a = 32'h1234_5678;
    wait_z_stb(k);
    check("bp_latency", 32'(k), 32'(exp_lat(32'h0100_0003, 7)));
    check("bp_z", z, 32'h4B80_0002);
    z_held = z;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = a + 32'h1111_1111;
      check("bp_z_stable", z, z_held);
      check("bp_z_stb_held", {31'd0, z_stb}, 32'd1);
      check("bp_a_ack_low", {31'd0, a_ack}, 32'd0);
    end
    a = 32'hFFFF_FFFF;
    @(negedge clk);
    z_ack = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_stb_drop", {31'd0, z_stb}, 32'd0);
    check("bp_hs_ack", {31'd0, a_ack}, 32'd1);
    check("bp_hs_z_kept", z, 32'h4B80_0002);
    @(posedge clk); #1;
    a_stb = 1'b0;
    check("bp_next_accepted", {31'd0, a_ack}, 32'd0);
    wait_z_stb(k);
    check("bp_next_latency", 32'(k), 32'(exp_lat(32'hFFFF_FFFF, 0)));
    check("bp_next_z", z, 32'h4F80_0000);
    @(posedge clk); #1;

    // Reset in the middle of a long normalisation.
    wait_a_ack();
    @(negedge clk);
    a     = 32'h0000_0001;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_a_ack", {31'd0, a_ack}, 32'd0);
    check("mid_rst_z_stb", {31'd0, z_stb}, 32'd0);
    check("mid_rst_z", z, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rel_a_ack", {31'd0, a_ack}, 32'd1);
    do_conv("after_rst", 32'd100, 25, 32'h42C8_0000);

    // Reset while a result is waiting must clear z_stb and z without a clock.
    z_ack = 1'b0;
    wait_a_ack();
    @(negedge clk);
    a     = 32'h0200_0003;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    wait_z_stb(k);
    check("putz_z", z, 32'h4C00_0001);
    #2;
    rst = 1'b1;
    #1;
    check("putz_rst_z_stb", {31'd0, z_stb}, 32'd0);
    check("putz_rst_z", z, 32'd0);
    check("putz_rst_a_ack", {31'd0, a_ack}, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    z_ack = 1'b1;
    do_conv("recover", 32'h00FF_FFFF, 8, 32'h4B7F_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
